// File: rtl/game_sequencer.sv
// Game flow sequencer: IDLE -> COUNTDOWN -> PLAY -> OVER, with a one-second
// divider shared by the countdown and the in-game seconds tick.
module game_sequencer #(
    parameter int unsigned TICK_DIV = 100000000,
    parameter int unsigned CD_SECS  = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        pause,
    input  logic        hit,
    input  logic        miss,
    input  logic        time_up,
    output logic [1:0]  gamestate,
    output logic        sec_tick,
    output logic        timer_rst,
    output logic [15:0] score,
    output logic [3:0]  cd_value,
    output logic        paused
);

    localparam int unsigned      DIV_W     = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_DIV - 1);
    localparam logic [3:0]       CD_LOAD   = 4'(CD_SECS);
    localparam logic [15:0]      SCORE_MAX = 16'd9999;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_CD   = 2'b01;
    localparam logic [1:0] S_PLAY = 2'b10;
    localparam logic [1:0] S_OVER = 2'b11;

    logic [1:0]       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [15:0]      score_q, score_d;
    logic [3:0]       cd_q, cd_d;
    logic             paused_q, paused_d;
    logic             trst_q, trst_d;
    logic             run;
    logic             tick;

    // The divider freezes while paused so a resumed second keeps its partial count.
    assign run  = (state_q == S_CD) || ((state_q == S_PLAY) && !paused_q);
    assign tick = run && (div_q == DIV_LAST);

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        score_d  = score_q;
        cd_d     = cd_q;
        paused_d = paused_q;
        trst_d   = 1'b0;

        if (run) begin
            div_d = tick ? '0 : div_q + DIV_W'(1);
        end

        case (state_q)
            S_IDLE, S_OVER: begin
                if (start) begin
                    state_d  = S_CD;
                    div_d    = '0;
                    score_d  = '0;
                    cd_d     = CD_LOAD;
                    paused_d = 1'b0;
                    trst_d   = 1'b1;
                end
            end
            S_CD: begin
                if (tick) begin
                    if (cd_q == 4'd1) begin
                        state_d  = S_PLAY;
                        cd_d     = '0;
                        paused_d = 1'b0;
                    end else begin
                        cd_d = cd_q - 4'd1;
                    end
                end
            end
            S_PLAY: begin
                if (!paused_q) begin
                    if (hit && !miss && (score_q != SCORE_MAX)) begin
                        score_d = score_q + 16'd1;
                    end else if (miss && !hit && (score_q != 16'd0)) begin
                        score_d = score_q - 16'd1;
                    end
                end
                if (pause) begin
                    paused_d = !paused_q;
                end
                if (time_up) begin
                    state_d  = S_OVER;
                    paused_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            div_q    <= '0;
            score_q  <= '0;
            cd_q     <= '0;
            paused_q <= 1'b0;
            trst_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            score_q  <= score_d;
            cd_q     <= cd_d;
            paused_q <= paused_d;
            trst_q   <= trst_d;
        end
    end

    assign gamestate = state_q;
    assign sec_tick  = tick && (state_q == S_PLAY);
    assign timer_rst = trst_q;
    assign score     = score_q;
    assign cd_value  = cd_q;
    assign paused    = paused_q;

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000000: clk cycles per one-second tick, legal range 2..2^27.
REQ-002 SHALL have parameter CD_SECS, default 3: countdown length in seconds, legal range 1..9.
REQ-003 SHALL have port clk, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: single-cycle pulse, already debounced, requests a new game.
REQ-006 SHALL have port pause, input, 1 bit: single-cycle pulse that toggles pause while playing.
REQ-007 SHALL have port hit, input, 1 bit: single-cycle pulse marking a correctly played note.
REQ-008 SHALL have port miss, input, 1 bit: single-cycle pulse marking a missed note.
REQ-009 SHALL have port time_up, input, 1 bit: level from the timer block; 1 means the game time has expired.
REQ-010 SHALL have port gamestate, output, 2 bits: 00 IDLE, 01 COUNTDOWN, 10 PLAY, 11 OVER.
REQ-011 SHALL have port sec_tick, output, 1 bit: one-cycle pulse per elapsed second in PLAY, driving the timer's slow clock.
REQ-012 SHALL have port timer_rst, output, 1 bit: one-cycle pulse that re-arms the timer block.
REQ-013 SHALL have port score, output, 16 bits: binary score, range 0..9999.
REQ-014 SHALL have port cd_value, output, 4 bits: seconds remaining in COUNTDOWN, 0 in every other state.
REQ-015 SHALL have port paused, output, 1 bit: 1 while PLAY is frozen.

Function
REQ-016 SHALL keep an internal divider div of 0..TICK_DIV-1; it increments each cycle it is running, and at TICK_DIV-1 it wraps to 0 and produces an internal tick in that same cycle.
REQ-017 SHALL run div only in COUNTDOWN, and in PLAY while paused=0; otherwise div holds its value.
REQ-018 In IDLE or OVER, start SHALL, in one cycle: go to COUNTDOWN, clear div and score, load cd_value=CD_SECS, and assert timer_rst for that cycle.
REQ-019 In COUNTDOWN, each internal tick SHALL decrement cd_value; a tick with cd_value=1 SHALL go to PLAY with cd_value=0 and paused=0.
REQ-020 In COUNTDOWN and PLAY, start SHALL be ignored.
REQ-021 In PLAY with paused=0, sec_tick SHALL equal the internal tick; in all other cases sec_tick=0.
REQ-022 In PLAY, pause SHALL toggle paused; div SHALL keep its count across a pause.
REQ-023 In PLAY with paused=0, the score SHALL update as follows: hit alone adds 1, saturating at 9999; miss alone subtracts 1, saturating at 0; hit and miss together leave it unchanged.
REQ-024 While paused=1, or in any state other than PLAY, hit and miss SHALL be ignored.
REQ-025 time_up=1 in PLAY SHALL go to OVER on the next edge, regardless of paused, and clear paused; a hit or miss in that same cycle SHALL still be scored.
REQ-026 time_up SHALL be ignored outside PLAY.
REQ-027 In OVER, score SHALL be held and sec_tick=0.
REQ-028 All outputs SHALL be registered, except sec_tick, which may be decoded from registered state in the same cycle.

Reset
REQ-029 While reset=1, the block SHALL force: gamestate=00, score=0, cd_value=0, paused=0, div=0, timer_rst=0, sec_tick=0.
REQ-030 Reset asserted mid-game (any state) SHALL abandon the game immediately without waiting for a clock edge.
REQ-031 After reset deasserts, the block SHALL remain in IDLE until start.

Verification
REQ-032 Countdown: TICK_DIV=4, CD_SECS=3, start in IDLE -> timer_rst high for 1 cycle; cd_value 3,2,1 at 4-cycle spacing; gamestate=10 exactly 12 cycles after start; sec_tick every 4th cycle thereafter.
REQ-033 Scoring: 5 hits, then 2 misses, then hit+miss together in PLAY -> score=3; from score 0, a miss -> score stays 0; 10000 hits -> score=9999.
REQ-034 Pause: pause after 2 div counts, hold 20 cycles, pause again -> no sec_tick and hits ignored while paused; the next sec_tick arrives 2 cycles after resume.
REQ-035 End of game: time_up=1 in PLAY with a concurrent hit -> gamestate=11 next cycle, score includes that hit; later time_up toggles, hits and pause -> no change; start -> COUNTDOWN, score=0.
REQ-036 Reset: async reset pulse between clock edges during PLAY with score=7 -> all outputs at reset values before the next edge; start ignored in COUNTDOWN.
